// File: rtl/progmem_loader.sv
// progmem_loader: single-port program memory with a nibble-serial loader.
// After reset the whole array is cleared. The CPU then reads and writes it,
// or a loader session streams a full image in, one LD_W nibble at a time.
module progmem_loader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int LD_W   = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    input  logic              write_en,
    output logic [DATA_W-1:0] dout,
    output logic              busy,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [LD_W-1:0]   ld_nib,
    output logic              ld_ready,
    output logic              ld_done
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NPW   = DATA_W / LD_W;
    localparam int CNT_W = (NPW > 1) ? $clog2(NPW) : 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  LAST_NIB  = CNT_W'(NPW - 1);

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] wptr;
    logic [CNT_W-1:0]  nib_cnt;
    logic [DATA_W-1:0] asm_word;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              nib_acc;
    logic              word_done;
    logic [DATA_W-1:0] asm_next;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // A nibble is taken only while the loader handshake is open in LOAD.
    assign nib_acc   = (state == LOAD) && ld_valid && ld_ready;
    assign word_done = nib_acc && (nib_cnt == LAST_NIB);
    // New nibble enters at the LSBs; older nibbles move toward the MSBs.
    assign asm_next  = (asm_word << LD_W) | DATA_W'(ld_nib);

    // Single memory write port shared by clear sweep, CPU writes and the loader.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wdata = din;
        if (resetn) begin
            case (state)
                CLEAR: begin
                    mem_we    = 1'b1;
                    mem_waddr = ptr;
                    mem_wdata = '0;
                end
                IDLE: begin
                    mem_we = write_en;
                end
                LOAD: begin
                    if (word_done) begin
                        mem_we    = 1'b1;
                        mem_waddr = wptr;
                        mem_wdata = asm_next;
                    end
                end
                default: begin
                    mem_we = 1'b0;
                end
            endcase
        end
    end

    // Memory array; contents are initialised by the clear sweep, not by reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Word assembly shift register; pure datapath, loaded on each accepted nibble.
    always_ff @(posedge clk) begin
        if (nib_acc) begin
            asm_word <= asm_next;
        end
    end

    // Control FSM with registered status outputs and registered read data.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= CLEAR;
            ptr      <= '0;
            wptr     <= '0;
            nib_cnt  <= '0;
            dout     <= '0;
            ld_ready <= 1'b0;
            ld_done  <= 1'b0;
            busy     <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    if (ptr == LAST_ADDR) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                IDLE: begin
                    dout <= mem[addr];
                    if (ld_start) begin
                        state    <= LOAD;
                        wptr     <= '0;
                        nib_cnt  <= '0;
                        ld_done  <= 1'b0;
                        ld_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (nib_acc) begin
                        if (nib_cnt == LAST_NIB) begin
                            nib_cnt <= '0;
                            if (wptr == LAST_ADDR) begin
                                state    <= IDLE;
                                ld_ready <= 1'b0;
                                ld_done  <= 1'b1;
                                busy     <= 1'b0;
                            end else begin
                                wptr <= wptr + 1'b1;
                            end
                        end else begin
                            nib_cnt <= nib_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= CLEAR;
                    ptr   <= '0;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule
